// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART/ALU sequencer slice
package uart_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    // Default datapath widths
    localparam int DEF_NB_DATA = 8;
    localparam int DEF_NB_OP   = 6;

    // Inter-byte timeout: 10 ms at 100 MHz
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    // Baud generator constants shared with the UART pair
    localparam int CLKS_PER_TICK = 326;
    localparam int TICKS_PER_BIT = 16;

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// rtl/uart_alu_sequencer_if.sv - rx/tx/alu signal bundle around the sequencer
interface uart_alu_sequencer_if
    import uart_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_OP   = DEF_NB_OP
);

    // Receiver side
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;

    // Combinational ALU result fed back from the operand registers
    logic [NB_DATA-1:0] i_alu_result;

    // Transmitter side
    logic               i_tx_done;

    // Operand / opcode registers presented to the ALU
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;

    // Transmit request
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;

    // Status
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    // Sequencer view
    modport master (
        input  i_rx_data,
        input  i_rx_done,
        input  i_alu_result,
        input  i_tx_done,
        output o_data_a,
        output o_data_b,
        output o_op,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_timeout,
        output o_overrun
    );

    // Peripheral view: UART pair and ALU
    modport slave (
        output i_rx_data,
        output i_rx_done,
        output i_alu_result,
        output i_tx_done,
        input  o_data_a,
        input  o_data_b,
        input  o_op,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_timeout,
        input  o_overrun
    );

endinterface

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - registered rising-edge detector for done strobes
module edge_pulse (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;
    logic level_d;

    // Previous-cycle copy of the strobe
    always_comb begin
        level_d = i_level;
    end

    // Hold the copy; reset clears it so a strobe high out of reset counts once
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    // A long strobe yields a single pulse on its first cycle
    assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects A, B, opcode bytes and returns the ALU result
module uart_alu_sequencer
    import uart_pkg::*;
#(
    parameter int NB_DATA        = DEF_NB_DATA,
    parameter int NB_OP          = DEF_NB_OP,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_alu_sequencer_if.master bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic               rx_edge;
    logic               tx_edge;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_a_d;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_DATA-1:0] data_b_d;
    logic [NB_OP-1:0]   op_q;
    logic [NB_OP-1:0]   op_d;
    logic [NB_DATA-1:0] tx_data_q;
    logic [NB_DATA-1:0] tx_data_d;
    logic               timeout_q;
    logic               timeout_d;
    logic               overrun_q;
    logic               overrun_d;

    edge_pulse u_rx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (bus.i_rx_done),
        .o_pulse (rx_edge)
    );

    edge_pulse u_tx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (bus.i_tx_done),
        .o_pulse (tx_edge)
    );

    // Frame sequencing, inter-byte timeout and overrun detection
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            ST_WAIT_A: begin
                // No timeout here: an idle line between frames is normal
                if (rx_edge) begin
                    data_a_d = bus.i_rx_data;
                    state_d  = ST_WAIT_B;
                end
            end

            ST_WAIT_B: begin
                // A byte arriving on the terminal count still belongs to the frame
                if (rx_edge) begin
                    data_b_d = bus.i_rx_data;
                    state_d  = ST_WAIT_OP;
                end else if (cnt_q == CNT_TERM) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_WAIT_OP: begin
                if (rx_edge) begin
                    op_d    = bus.i_rx_data[NB_OP-1:0];
                    state_d = ST_LOAD;
                end else if (cnt_q == CNT_TERM) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_LOAD: begin
                // Operand registers settled last cycle, so the ALU output is valid now
                tx_data_d = bus.i_alu_result;
                overrun_d = rx_edge;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                overrun_d = rx_edge;
                state_d   = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                // Bytes arriving before the transmitter finishes are dropped
                overrun_d = rx_edge;
                if (tx_edge) begin
                    state_d = ST_WAIT_A;
                end
            end

            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // State, counter, datapath registers and status pulses
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_WAIT_A;
            cnt_q     <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_op       = op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = (state_q == ST_SEND);
    assign bus.o_busy     = (state_q == ST_LOAD) || (state_q == ST_SEND) ||
                            (state_q == ST_WAIT_TX);
    assign bus.o_timeout  = timeout_q;
    assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO      = 100;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    uart_alu_sequencer_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_sequencer #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_to    = 0;
    int n_ov    = 0;
    int exp_starts = 0;

    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;

    vec_t       tbl [8];
    logic [5:0] opset [5];

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_op);

    always @(negedge clk) begin
        if (bus.o_tx_start) n_start = n_start + 1;
        if (bus.o_timeout)  n_to    = n_to + 1;
        if (bus.o_overrun)  n_ov    = n_ov + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int len, input int gap);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        repeat (len) step();
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'($urandom);
        repeat (gap) step();
    endtask

    task automatic send_op(input logic [7:0] op, input logic [7:0] res);
        bus.i_rx_data = op;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'($urandom);
        chk("op_reg", int'(bus.o_op), int'(op[5:0]));
        chk("busy_load", int'(bus.o_busy), 1);
        chk("start_early", int'(bus.o_tx_start), 0);
        step();
        chk("tx_start", int'(bus.o_tx_start), 1);
        chk("tx_data", int'(bus.o_tx_data), int'(res));
        step();
        chk("start_width", int'(bus.o_tx_start), 0);
        chk("busy_wait_tx", int'(bus.o_busy), 1);
        exp_op = op[5:0];
        exp_tx = res;
        exp_starts++;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] res, input int len_a, input int len_b,
                             input int gap);
        send_byte(a, len_a, gap);
        chk("cap_a", int'(bus.o_data_a), int'(a));
        send_byte(b, len_b, gap);
        chk("cap_b", int'(bus.o_data_b), int'(b));
        exp_a = a;
        exp_b = b;
        send_op(op, res);
    endtask

    task automatic finish_tx(input int w, input bit ovr, input int tx_len);
        int o0;
        repeat (w) step();
        if (ovr) begin
            o0 = n_ov;
            send_byte(8'h55, 1, 1);
            chk("overrun_pulse", n_ov - o0, 1);
            chk("ovr_keep_a", int'(bus.o_data_a), int'(exp_a));
        end
        chk("tx_hold", int'(bus.o_tx_data), int'(exp_tx));
        chk("busy_before_done", int'(bus.o_busy), 1);
        bus.i_tx_done = 1'b1;
        step();
        chk("busy_clear", int'(bus.o_busy), 0);
        repeat (tx_len - 1) step();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic wait_timeout(input string name, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (!bus.o_timeout && cyc < 300) begin
            step();
            cyc++;
        end
        chk(name, cyc, exp_cycles);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int t0;
        int nb;
        int idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;

        tbl[0] = '{8'h0F, 8'h01, 8'h20, 8'h10};
        tbl[1] = '{8'h10, 8'h03, 8'h22, 8'h0D};
        tbl[2] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
        tbl[3] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
        tbl[4] = '{8'hFF, 8'h0F, 8'h26, 8'hF0};
        tbl[5] = '{8'h80, 8'h80, 8'h20, 8'h00};
        tbl[6] = '{8'h12, 8'h34, 8'hE0, 8'h46};
        tbl[7] = '{8'h00, 8'h01, 8'h22, 8'hFF};
        opset[0] = 6'h20;
        opset[1] = 6'h22;
        opset[2] = 6'h24;
        opset[3] = 6'h25;
        opset[4] = 6'h26;

        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("rst_a", int'(bus.o_data_a), 0);
        chk("rst_b", int'(bus.o_data_b), 0);
        chk("rst_op", int'(bus.o_op), 0);
        chk("rst_tx_data", int'(bus.o_tx_data), 0);
        chk("rst_tx_start", int'(bus.o_tx_start), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_timeout", int'(bus.o_timeout), 0);
        chk("rst_overrun", int'(bus.o_overrun), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Table-driven frames, back-to-back after each tx_done
        for (int i = 0; i < 8; i++) begin
            s0 = n_start;
            run_frame(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, 1, 1, 1);
            finish_tx(2, 1'b0, 1);
            chk("one_start", n_start - s0, 1);
        end

        // Held strobe counts as a single byte (A only)
        send_byte(8'hAA, 5, 1);
        chk("held_a", int'(bus.o_data_a), 8'hAA);
        chk("held_b_kept", int'(bus.o_data_b), int'(exp_b));
        send_byte(8'h33, 1, 1);
        chk("held_next_is_b", int'(bus.o_data_b), 8'h33);
        chk("held_op_kept", int'(bus.o_op), int'(exp_op));
        exp_a = 8'hAA;
        exp_b = 8'h33;
        send_op(8'h20, 8'hDD);
        finish_tx(1, 1'b0, 2);

        // Timeout after a lone A byte, then a fresh frame
        t0 = n_to;
        send_byte(8'h12, 1, 0);
        wait_timeout("timeout_latency", 100);
        step();
        chk("timeout_width", int'(bus.o_timeout), 0);
        chk("timeout_once", n_to - t0, 1);
        chk("timeout_keep_a", int'(bus.o_data_a), 8'h12);
        run_frame(8'h21, 8'h05, 8'h22, 8'h1C, 1, 1, 1);
        finish_tx(0, 1'b0, 1);

        // Overrun during WAIT_TX
        run_frame(8'h40, 8'h02, 8'h25, 8'h42, 1, 1, 2);
        finish_tx(3, 1'b1, 1);
        run_frame(8'h07, 8'h09, 8'h20, 8'h10, 1, 1, 1);
        finish_tx(0, 1'b0, 1);

        // Byte arriving on the terminal count is captured, no timeout
        t0 = n_to;
        bus.i_rx_data = 8'h9A;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
        repeat (99) step();
        chk("tie_no_early_to", n_to - t0, 0);
        send_byte(8'h3C, 1, 1);
        chk("tie_cap_b", int'(bus.o_data_b), 8'h3C);
        chk("tie_no_timeout", n_to - t0, 0);
        exp_a = 8'h9A;
        exp_b = 8'h3C;
        send_op(8'h26, 8'hA6);
        finish_tx(0, 1'b0, 1);

        // Asynchronous reset between B and opcode
        t0 = n_to;
        send_byte(8'h11, 1, 1);
        send_byte(8'h22, 1, 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_a", int'(bus.o_data_a), 0);
        chk("mid_rst_b", int'(bus.o_data_b), 0);
        chk("mid_rst_op", int'(bus.o_op), 0);
        chk("mid_rst_tx_data", int'(bus.o_tx_data), 0);
        chk("mid_rst_busy", int'(bus.o_busy), 0);
        step();
        step();
        rst = 1'b0;
        send_byte(8'h77, 1, 1);
        chk("post_rst_a", int'(bus.o_data_a), 8'h77);
        chk("post_rst_b", int'(bus.o_data_b), 0);
        send_byte(8'h08, 1, 1);
        chk("post_rst_b2", int'(bus.o_data_b), 8'h08);
        exp_a = 8'h77;
        exp_b = 8'h08;
        send_op(8'h20, 8'h7F);
        finish_tx(1, 1'b0, 1);
        chk("rst_no_timeout", n_to - t0, 0);

        // Randomised frames against the reference model
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                t0 = n_to;
                nb = $urandom_range(1, 2);
                a = 8'($urandom);
                if (nb == 2) begin
                    send_byte(a, $urandom_range(1, 3), 1);
                    b = 8'($urandom);
                    send_byte(b, 1, 0);
                    exp_b = b;
                end else begin
                    send_byte(a, 1, 0);
                end
                exp_a = a;
                wait_timeout("rnd_timeout", 100);
                step();
                chk("rnd_timeout_once", n_to - t0, 1);
                chk("rnd_keep_a", int'(bus.o_data_a), int'(exp_a));
                chk("rnd_keep_b", int'(bus.o_data_b), int'(exp_b));
            end
            a  = 8'($urandom);
            b  = 8'($urandom);
            idx = $urandom_range(0, 4);
            op = {2'($urandom_range(0, 3)), opset[idx]};
            s0 = n_start;
            run_frame(a, b, op, alu_ref(a, b, op[5:0]),
                      $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4));
            finish_tx($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            chk("rnd_one_start", n_start - s0, 1);
        end

        step();
        chk("total_starts", n_start, exp_starts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
